// File: rtl/reconstruct_l4_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reconstruct_l4_if : sample/handshake bundle for reconstruct_l4       |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface reconstruct_l4_if #(
    parameter int INTERNAL_WIDTH = 48
);
    logic                             din_valid;
    logic                             din_sync;
    logic signed [INTERNAL_WIDTH-1:0] a4_0;
    logic signed [INTERNAL_WIDTH-1:0] d4_0;
    logic                             dout_valid;
    logic signed [INTERNAL_WIDTH-1:0] a3_0;
    logic signed [INTERNAL_WIDTH-1:0] a3_1;
    logic                             sat_flag;

    modport master (
        output din_valid, din_sync, a4_0, d4_0,
        input  dout_valid, a3_0, a3_1, sat_flag
    );

    modport slave (
        input  din_valid, din_sync, a4_0, d4_0,
        output dout_valid, a3_0, a3_1, sat_flag
    );
endinterface
`default_nettype wire

// File: rtl/reconstruct_l4.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reconstruct_l4 : Sym4 inverse DWT stage, (a4,d4) -> (a3 even, odd)   |
// | Option: define RECON_L4_SAT_EN for clamping + sticky sat_flag.       |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module reconstruct_l4 #(
    parameter int                          INTERNAL_WIDTH = 48,
    parameter int                          COEF_WIDTH     = 25,
    parameter int                          COEF_FRAC      = 24,
    parameter logic signed [COEF_WIDTH-1:0] DEC_H0 = -25'sd635569,
    parameter logic signed [COEF_WIDTH-1:0] DEC_H1 = -25'sd248601,
    parameter logic signed [COEF_WIDTH-1:0] DEC_H2 =  25'sd4174328,
    parameter logic signed [COEF_WIDTH-1:0] DEC_H3 =  25'sd6742249,
    parameter logic signed [COEF_WIDTH-1:0] DEC_H4 =  25'sd2498612,
    parameter logic signed [COEF_WIDTH-1:0] DEC_H5 = -25'sd832314,
    parameter logic signed [COEF_WIDTH-1:0] DEC_H6 = -25'sd105730,
    parameter logic signed [COEF_WIDTH-1:0] DEC_H7 =  25'sd270307
) (
    input  logic             clk,
    input  logic             rst,
    reconstruct_l4_if.slave  l4_if
);
    localparam int PW  = INTERNAL_WIDTH + COEF_WIDTH;
    localparam int SW  = PW + 2;
    localparam int AW  = PW + 3;
    localparam int SHW = AW - COEF_FRAC;

    localparam logic signed [COEF_WIDTH-1:0] C_DEC_H [8] =
        '{DEC_H0, DEC_H1, DEC_H2, DEC_H3, DEC_H4, DEC_H5, DEC_H6, DEC_H7};
    localparam logic signed [AW-1:0] C_RND =
        {{(AW-COEF_FRAC){1'b0}}, 1'b1, {(COEF_FRAC-1){1'b0}}};
`ifdef RECON_L4_SAT_EN
    localparam logic signed [SHW-1:0] C_MAX =
        {{(SHW-INTERNAL_WIDTH+1){1'b0}}, {(INTERNAL_WIDTH-1){1'b1}}};
    localparam logic signed [SHW-1:0] C_MIN = ~C_MAX;
`endif

    function automatic logic signed [COEF_WIDTH-1:0] g0(input int i);
        return C_DEC_H[7-i];
    endfunction

    // Highpass synthesis taps alternate sign, starting negative at i=0
    function automatic logic signed [COEF_WIDTH-1:0] g1(input int i);
        return (i % 2 == 0) ? -C_DEC_H[7-i] : C_DEC_H[7-i];
    endfunction

    logic signed [INTERNAL_WIDTH-1:0] a_hist_q [4];
    logic signed [INTERNAL_WIDTH-1:0] a_hist_d [4];
    logic signed [INTERNAL_WIDTH-1:0] d_hist_q [4];
    logic signed [INTERNAL_WIDTH-1:0] d_hist_d [4];
    logic [3:0]                       vld_q;

    logic signed [PW-1:0] pa_ev_q [4];
    logic signed [PW-1:0] pd_ev_q [4];
    logic signed [PW-1:0] pa_od_q [4];
    logic signed [PW-1:0] pd_od_q [4];

    logic signed [SW-1:0] ev_lo_q, ev_hi_q, od_lo_q, od_hi_q;

    logic signed [AW-1:0]             ev_sum, od_sum;
    logic signed [SHW-1:0]            ev_sh, od_sh;
    logic signed [INTERNAL_WIDTH-1:0] a3_0_q, a3_0_d, a3_1_q, a3_1_d;
    logic                             sat_q, sat_d;
    logic                             unused_bits;

    // S1: history shift; a sync sample drops all older entries
    always_comb begin : s1_next
        for (int k = 0; k < 4; k++) begin
            a_hist_d[k] = a_hist_q[k];
            d_hist_d[k] = d_hist_q[k];
        end
        if (l4_if.din_valid) begin
            a_hist_d[0] = l4_if.a4_0;
            d_hist_d[0] = l4_if.d4_0;
            for (int k = 1; k < 4; k++) begin
                a_hist_d[k] = l4_if.din_sync ? '0 : a_hist_q[k-1];
                d_hist_d[k] = l4_if.din_sync ? '0 : d_hist_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin : s1_reg
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                a_hist_q[k] <= '0;
                d_hist_q[k] <= '0;
            end
            vld_q <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                a_hist_q[k] <= a_hist_d[k];
                d_hist_q[k] <= d_hist_d[k];
            end
            vld_q <= {vld_q[2:0], l4_if.din_valid};
        end
    end

    always_ff @(posedge clk) begin : s2_products
        for (int k = 0; k < 4; k++) begin
            pa_ev_q[k] <= PW'(a_hist_q[k]) * PW'(g0(2*k));
            pd_ev_q[k] <= PW'(d_hist_q[k]) * PW'(g1(2*k));
            pa_od_q[k] <= PW'(a_hist_q[k]) * PW'(g0(2*k+1));
            pd_od_q[k] <= PW'(d_hist_q[k]) * PW'(g1(2*k+1));
        end
    end

    always_ff @(posedge clk) begin : s3_partial
        ev_lo_q <= SW'(pa_ev_q[0]) + SW'(pd_ev_q[0]) + SW'(pa_ev_q[1]) + SW'(pd_ev_q[1]);
        ev_hi_q <= SW'(pa_ev_q[2]) + SW'(pd_ev_q[2]) + SW'(pa_ev_q[3]) + SW'(pd_ev_q[3]);
        od_lo_q <= SW'(pa_od_q[0]) + SW'(pd_od_q[0]) + SW'(pa_od_q[1]) + SW'(pd_od_q[1]);
        od_hi_q <= SW'(pa_od_q[2]) + SW'(pd_od_q[2]) + SW'(pa_od_q[3]) + SW'(pd_od_q[3]);
    end

    // S4: round half up, drop fraction, then clamp or wrap; hold when idle
    always_comb begin : s4_next
        ev_sum = AW'(ev_lo_q) + AW'(ev_hi_q) + C_RND;
        od_sum = AW'(od_lo_q) + AW'(od_hi_q) + C_RND;
        ev_sh  = ev_sum[AW-1:COEF_FRAC];
        od_sh  = od_sum[AW-1:COEF_FRAC];
        a3_0_d = a3_0_q;
        a3_1_d = a3_1_q;
        sat_d  = sat_q;
        if (vld_q[2]) begin
`ifdef RECON_L4_SAT_EN
            if (ev_sh > C_MAX) begin
                a3_0_d = C_MAX[INTERNAL_WIDTH-1:0];
                sat_d  = 1'b1;
            end else if (ev_sh < C_MIN) begin
                a3_0_d = C_MIN[INTERNAL_WIDTH-1:0];
                sat_d  = 1'b1;
            end else begin
                a3_0_d = ev_sh[INTERNAL_WIDTH-1:0];
            end
            if (od_sh > C_MAX) begin
                a3_1_d = C_MAX[INTERNAL_WIDTH-1:0];
                sat_d  = 1'b1;
            end else if (od_sh < C_MIN) begin
                a3_1_d = C_MIN[INTERNAL_WIDTH-1:0];
                sat_d  = 1'b1;
            end else begin
                a3_1_d = od_sh[INTERNAL_WIDTH-1:0];
            end
`else
            a3_0_d = ev_sh[INTERNAL_WIDTH-1:0];
            a3_1_d = od_sh[INTERNAL_WIDTH-1:0];
`endif
        end
`ifndef RECON_L4_SAT_EN
        sat_d = 1'b0;
`endif
    end

`ifdef RECON_L4_SAT_EN
    assign unused_bits = ^{ev_sum[COEF_FRAC-1:0], od_sum[COEF_FRAC-1:0]};
`else
    assign unused_bits = ^{ev_sum[COEF_FRAC-1:0], od_sum[COEF_FRAC-1:0],
                           ev_sh[SHW-1:INTERNAL_WIDTH], od_sh[SHW-1:INTERNAL_WIDTH]};
`endif

    always_ff @(posedge clk) begin : s4_reg
        if (rst) begin
            a3_0_q <= '0;
            a3_1_q <= '0;
            sat_q  <= 1'b0;
        end else begin
            a3_0_q <= a3_0_d;
            a3_1_q <= a3_1_d;
            sat_q  <= sat_d;
        end
    end

    assign l4_if.dout_valid = vld_q[3];
    assign l4_if.a3_0       = a3_0_q;
    assign l4_if.a3_1       = a3_1_q;
    assign l4_if.sat_flag   = sat_q;
endmodule
`default_nettype wire

// File: tb/tb_reconstruct_l4.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_reconstruct_l4 : random stimulus, reference model, scoreboard     |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_reconstruct_l4;
    localparam int IW = 48;
    localparam int CW = 25;
    localparam int CF = 24;
    localparam logic signed [CW-1:0] H [8] = '{
        -25'sd635569, -25'sd248601, 25'sd4174328, 25'sd6742249,
        25'sd2498612, -25'sd832314, -25'sd105730, 25'sd270307};

    typedef struct {
        logic signed [IW-1:0] e;
        logic signed [IW-1:0] o;
        logic                 sat;
        int                   cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic zero_chk = 1'b0;

    exp_t                 sb[$];
    exp_t                 mx;
    logic signed [IW-1:0] ha [4];
    logic signed [IW-1:0] hd [4];
    logic                 m_sat;
    logic signed [IW-1:0] big;

    reconstruct_l4_if #(.INTERNAL_WIDTH(IW)) bus ();

    reconstruct_l4 #(
        .INTERNAL_WIDTH (IW),
        .COEF_WIDTH     (CW),
        .COEF_FRAC      (CF)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .l4_if (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synthesis filters: G0[i] = H[7-i], G1[i] = (-1)^(i+1) * H[7-i]
    function automatic logic signed [127:0] coef(input int bank, input int i);
        logic signed [127:0] h;
        h = 128'(H[7-i]);
        if (bank == 1 && ((i + 1) % 2 == 1)) h = -h;
        return h;
    endfunction

    function automatic logic signed [IW-1:0] ref_out(input int p, output logic clip);
        logic signed [127:0] acc, y, maxv, minv;
        acc = 0;
        for (int k = 0; k < 4; k++)
            acc = acc + 128'(ha[k]) * coef(0, 2*k+p) + 128'(hd[k]) * coef(1, 2*k+p);
        y    = (acc + (128'sd1 <<< (CF-1))) >>> CF;
        maxv = (128'sd1 <<< (IW-1)) - 128'sd1;
        minv = -(128'sd1 <<< (IW-1));
        clip = 1'b0;
`ifdef RECON_L4_SAT_EN
        if (y > maxv) begin
            y = maxv; clip = 1'b1;
        end else if (y < minv) begin
            y = minv; clip = 1'b1;
        end
`else
        if (y > maxv || y < minv) clip = 1'b0;
`endif
        return y[IW-1:0];
    endfunction

    function automatic logic signed [IW-1:0] rnd48();
        logic [63:0] r;
        r = {$urandom, $urandom};
        if ($urandom_range(0, 1) == 1) return r[IW-1:0];
        return IW'($signed(r[31:0]));
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 4; k++) begin
            ha[k] = '0;
            hd[k] = '0;
        end
        m_sat = 1'b0;
    endtask

    task automatic drive(input logic v, input logic s,
                         input logic signed [IW-1:0] a, input logic signed [IW-1:0] d);
        exp_t x;
        logic c0, c1;
        bus.din_valid = v;
        bus.din_sync  = s;
        bus.a4_0      = a;
        bus.d4_0      = d;
        if (v) begin
            for (int k = 3; k > 0; k--) begin
                ha[k] = s ? '0 : ha[k-1];
                hd[k] = s ? '0 : hd[k-1];
            end
            ha[0] = a;
            hd[0] = d;
            x.e   = ref_out(0, c0);
            x.o   = ref_out(1, c1);
            m_sat = m_sat | c0 | c1;
            x.sat = m_sat;
            x.cyc = cyc + 4;
            sb.push_back(x);
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        bus.din_valid = 1'b0;
        bus.din_sync  = 1'b0;
        bus.a4_0      = rnd48();
        bus.d4_0      = rnd48();
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        model_clear();
        zero_chk = 1'b1;
        @(negedge clk); #1;
        zero_chk = 1'b0;
        @(posedge clk); #1;
    endtask

    // Monitor: pop expectations whenever the DUT presents a pair
    always @(negedge clk) begin
        if (zero_chk) begin
            checks += 4;
            if (bus.dout_valid !== 1'b0) begin
                errors++; $display("FAIL reset_valid: got %0b, expected 0", bus.dout_valid);
            end
            if (bus.a3_0 !== '0) begin
                errors++; $display("FAIL reset_a3_0: got %0d, expected 0", bus.a3_0);
            end
            if (bus.a3_1 !== '0) begin
                errors++; $display("FAIL reset_a3_1: got %0d, expected 0", bus.a3_1);
            end
            if (bus.sat_flag !== 1'b0) begin
                errors++; $display("FAIL reset_sat: got %0b, expected 0", bus.sat_flag);
            end
        end else if (bus.dout_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid cyc=%0d: got a3_0=%0d a3_1=%0d, expected no output",
                         cyc, bus.a3_0, bus.a3_1);
            end else begin
                mx = sb.pop_front();
                if (mx.e !== bus.a3_0 || mx.o !== bus.a3_1 || mx.sat !== bus.sat_flag || mx.cyc != cyc) begin
                    errors++;
                    $display("FAIL out_pair: got a3_0=%0d a3_1=%0d sat=%0b cyc=%0d, expected a3_0=%0d a3_1=%0d sat=%0b cyc=%0d",
                             bus.a3_0, bus.a3_1, bus.sat_flag, cyc, mx.e, mx.o, mx.sat, mx.cyc);
                end
            end
        end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
            checks++;
            errors++;
            mx = sb.pop_front();
            $display("FAIL missing_output: got no dout_valid by cyc=%0d, expected pair at cyc=%0d", cyc, mx.cyc);
        end
    end

    initial begin
        model_clear();
        big = {1'b0, {(IW-1){1'b1}}};
        @(posedge clk); #1;
        do_reset(3);

        // Lowpass impulse then highpass impulse
        drive(1'b1, 1'b1, 48'sd16777216, '0);
        repeat (3) drive(1'b1, 1'b0, '0, '0);
        drive(1'b1, 1'b1, '0, 48'sd16777216);
        repeat (3) drive(1'b1, 1'b0, '0, '0);
        repeat (6) drive(1'b0, 1'b0, rnd48(), rnd48());

        // Valid gaps 1,0,0,1,1
        drive(1'b1, 1'b1, rnd48(), rnd48());
        drive(1'b0, 1'b1, rnd48(), rnd48());
        drive(1'b0, 1'b0, rnd48(), rnd48());
        drive(1'b1, 1'b0, rnd48(), rnd48());
        drive(1'b1, 1'b0, rnd48(), rnd48());

        // Random stream with occasional sync restarts
        for (int i = 0; i < 80; i++)
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, rnd48(), rnd48());

        // Reset two cycles after the last valid input
        repeat (3) drive(1'b1, 1'b0, rnd48(), rnd48());
        drive(1'b0, 1'b0, rnd48(), rnd48());
        do_reset(1);
        repeat (5) drive(1'b0, 1'b0, rnd48(), rnd48());
        repeat (4) drive(1'b1, 1'b0, rnd48(), rnd48());
        repeat (6) drive(1'b0, 1'b0, rnd48(), rnd48());

        // Saturation: full-scale opposing inputs
        do_reset(2);
        drive(1'b1, 1'b1, big, -big);
        repeat (5) drive(1'b1, 1'b0, big, -big);
        repeat (3) drive(1'b1, 1'b0, rnd48(), rnd48());

        repeat (10) drive(1'b0, 1'b0, rnd48(), rnd48());
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
